diffeq_operand_driver: RTL

Initiator-side sequencer for the differentiator's nibble-load / ready / valid interface. It latches four 4-bit operands (x, dx, u, a) from a host-side start request and presents them one per cycle on in with the matching one-hot select (s1..s4). It then pulses ready, waits for valid, and captures the 16-bit result. It sits between a host/testbench controller and the differentiator, and is the block that drives that interface in system integration.

---
 rtl/diffeq_drv_pkg.sv | 34 +++
 rtl/diffeq_wait_counter.sv | 54 +++++
 rtl/diffeq_operand_driver.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/diffeq_drv_pkg.sv
// -----------------------------------------------------------------------------
// diffeq_drv_pkg
//   Shared types and constants for the differentiator operand driver.
//   - drv_state_e : sequencer state encoding
//   - *_DEF       : default widths and wait-cycle limit
//   - SEL_*       : one-hot select patterns, bit order {s4, s3, s2, s1}
// Related build macro: DIFF_DRV_TIMEOUT_EN (consumed by diffeq_operand_driver).
// -----------------------------------------------------------------------------
package diffeq_drv_pkg;

  localparam int          NIB_W_DEF          = 4;
  localparam int          DATA_W_DEF         = 16;
  localparam int          CNT_W_DEF          = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LD_X  = 3'd1,
    ST_LD_DX = 3'd2,
    ST_LD_U  = 3'd3,
    ST_LD_A  = 3'd4,
    ST_KICK  = 3'd5,
    ST_WAIT  = 3'd6,
    ST_DONE  = 3'd7
  } drv_state_e;

  // One-hot operand selects, bit order {s4, s3, s2, s1}
  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_X    = 4'b0001;
  localparam logic [3:0] SEL_DX   = 4'b0010;
  localparam logic [3:0] SEL_U    = 4'b0100;
  localparam logic [3:0] SEL_A    = 4'b1000;

endpackage

// File: rtl/diffeq_wait_counter.sv
// -----------------------------------------------------------------------------
// diffeq_wait_counter
//   Saturating up-counter that measures how long the driver sits waiting for
//   the differentiator. Clear has priority over enable; the count sticks at
//   all-ones. at_limit_o flags that the count equals LIMIT.
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   clr_i      - synchronous clear to zero
//   en_i       - count enable
//   cnt_o      - current count (registered)
//   at_limit_o - high while cnt_o == LIMIT
// -----------------------------------------------------------------------------
import diffeq_drv_pkg::*;

module diffeq_wait_counter #(
  parameter int          CNT_W = CNT_W_DEF,
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_limit_o
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q == LIMIT_V);

endmodule

// File: rtl/diffeq_operand_driver.sv
// -----------------------------------------------------------------------------
// diffeq_operand_driver
//   Initiator for the differentiator nibble-load / ready / valid interface.
//   On start (sampled in IDLE) it latches four operands, presents them one per
//   cycle on `in` with the matching one-hot select, pulses ready, waits for
//   valid and captures the result. All outputs come straight from flops.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | waiting for start, operands latched on start
//   LD_X    | s1=1, in=x
//   LD_DX   | s2=1, in=dx
//   LD_U    | s3=1, in=u
//   LD_A    | s4=1, in=a
//   KICK    | ready=1 for one cycle
//   WAIT    | count cycles until valid (or timeout)
//   DONE    | result_valid=1, result/wait_cycles updated
//
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   start                      - host request, sampled only in IDLE
//   x_in, dx_in, u_in, a_in    - operands
//   busy                       - high whenever not IDLE
//   s1..s4, in                 - operand select and nibble to differentiator
//   ready                      - one-cycle compute kick
//   out, valid                 - result and result-valid from differentiator
//   result, result_valid       - last captured result and its one-cycle pulse
//   wait_cycles                - WAIT cycles of last transaction (saturating)
//   timeout                    - high with result_valid on a timed-out txn
//
// Build option: define DIFF_DRV_TIMEOUT_EN to leave WAIT after TIMEOUT_CYCLES
// without valid. Otherwise WAIT only exits on valid and timeout stays 0.
// -----------------------------------------------------------------------------
import diffeq_drv_pkg::*;

module diffeq_operand_driver #(
  parameter int          DATA_W         = DATA_W_DEF,
  parameter int          NIB_W          = NIB_W_DEF,
  parameter int          CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NIB_W-1:0]  x_in,
  input  logic [NIB_W-1:0]  dx_in,
  input  logic [NIB_W-1:0]  u_in,
  input  logic [NIB_W-1:0]  a_in,
  output logic              busy,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              s4,
  output logic [NIB_W-1:0]  in,
  output logic              ready,
  input  logic [DATA_W-1:0] out,
  input  logic              valid,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [CNT_W-1:0]  wait_cycles,
  output logic              timeout
);

`ifdef DIFF_DRV_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  drv_state_e        state_q;
  logic [NIB_W-1:0]  dx_q;
  logic [NIB_W-1:0]  u_q;
  logic [NIB_W-1:0]  a_q;
  logic [3:0]        sel_q;
  logic [NIB_W-1:0]  in_q;
  logic              busy_q;
  logic              ready_q;
  logic [DATA_W-1:0] result_q;
  logic              result_valid_q;
  logic [CNT_W-1:0]  wait_cycles_q;
  logic              timeout_q;

  logic              cnt_clr;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_at_limit;

  // Counter restarts with each accepted start and only runs in WAIT while
  // valid is low, so its value on the valid cycle is the number of idle waits.
  assign cnt_clr = (state_q == ST_IDLE) && start;
  assign cnt_en  = (state_q == ST_WAIT) && !valid;

  diffeq_wait_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .cnt_o      (cnt),
    .at_limit_o (cnt_at_limit)
  );

  // Outputs are assigned for the state being entered, so each one is a flop
  // that already matches the new state in the cycle it becomes current.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      dx_q           <= '0;
      u_q            <= '0;
      a_q            <= '0;
      sel_q          <= SEL_NONE;
      in_q           <= '0;
      busy_q         <= 1'b0;
      ready_q        <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      wait_cycles_q  <= '0;
      timeout_q      <= 1'b0;
    end else begin
      sel_q          <= SEL_NONE;
      in_q           <= '0;
      ready_q        <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // x goes straight onto the bus; only the later operands need storage
            dx_q    <= dx_in;
            u_q     <= u_in;
            a_q     <= a_in;
            sel_q   <= SEL_X;
            in_q    <= x_in;
            busy_q  <= 1'b1;
            state_q <= ST_LD_X;
          end
        end

        ST_LD_X: begin
          sel_q   <= SEL_DX;
          in_q    <= dx_q;
          state_q <= ST_LD_DX;
        end

        ST_LD_DX: begin
          sel_q   <= SEL_U;
          in_q    <= u_q;
          state_q <= ST_LD_U;
        end

        ST_LD_U: begin
          sel_q   <= SEL_A;
          in_q    <= a_q;
          state_q <= ST_LD_A;
        end

        ST_LD_A: begin
          ready_q <= 1'b1;
          state_q <= ST_KICK;
        end

        ST_KICK: begin
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          // valid wins over a timeout reached on the same cycle
          if (valid) begin
            result_q       <= out;
            wait_cycles_q  <= cnt;
            result_valid_q <= 1'b1;
            state_q        <= ST_DONE;
          end else if (TO_EN && cnt_at_limit) begin
            result_q       <= '0;
            wait_cycles_q  <= cnt;
            result_valid_q <= 1'b1;
            timeout_q      <= 1'b1;
            state_q        <= ST_DONE;
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign s1           = sel_q[0];
  assign s2           = sel_q[1];
  assign s3           = sel_q[2];
  assign s4           = sel_q[3];
  assign in           = in_q;
  assign ready        = ready_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign wait_cycles  = wait_cycles_q;
  assign timeout      = timeout_q;

endmodule
